// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RV32I load/store unit: FSM states,
// funct3 size/sign codes and completion codes.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RESP_OK       = 2'b00;
  localparam logic [1:0] RESP_MISALIGN = 2'b01;
  localparam logic [1:0] RESP_ILLEGAL  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT  = 2'b11;

endpackage

// File: rtl/riscv_lsu_if.sv
// Request, memory-bus and completion signals of the LSU; the LSU takes the
// slave view, the core/memory side takes the master view.
interface riscv_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              resp_valid;
  logic [4:0]        resp_rd;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [1:0]        resp_code;
  logic              busy;

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output resp_valid, resp_rd, resp_rdata, resp_err, resp_code, busy
  );

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  resp_valid, resp_rd, resp_rdata, resp_err, resp_code, busy
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobe/replication and load lane select with
// sign or zero extension, all driven by funct3 and the low address bits.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {addrLo_i, 3'b000};
    case (funct3_i)
      F3_LB:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  rdata_o = {24'h0, shifted[7:0]};
      F3_LHU:  rdata_o = {16'h0, shifted[15:0]};
      default: rdata_o = rdata_i;
    endcase
  end

  // Every lane carries a copy of the store value so the strobe alone picks the target bytes.
  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        wstrb_o = 4'b0001 << addrLo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        wstrb_o = 4'b0011 << addrLo_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: validates a request, runs one registered memory
// access with an optional ack timeout, and reports a one-cycle completion.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input logic        clk,
  input logic        reset,
  riscv_lsu_if.slave bus
);

  lsu_state_e        state_q;
  logic              memReq_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [31:0]       memWdata_q;
  logic [3:0]        memWstrb_q;
  logic [2:0]        funct3_q;
  logic [1:0]        addrLo_q;
  logic              isStore_q;
  logic [4:0]        rd_q;
  logic [31:0]       cnt_q;
  logic              respValid_q;
  logic [4:0]        respRd_q;
  logic [31:0]       respRdata_q;
  logic              respErr_q;
  logic [1:0]        respCode_q;

  logic        reqReady;
  logic        opLoad;
  logic        opStore;
  logic        illegal;
  logic        misaligned;
  logic        timeoutHit;
  logic [4:0]  rd_d;
  logic [2:0]  alignF3;
  logic [1:0]  alignLo;
  logic [3:0]  alignStrb;
  logic [31:0] alignWdata;
  logic [31:0] alignRdata;

  always_comb begin
    opLoad     = bus.req_load & ~bus.req_store;
    opStore    = bus.req_store & ~bus.req_load;
    illegal    = 1'b1;
    if (opLoad) begin
      illegal = !(bus.req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    end else if (opStore) begin
      illegal = !(bus.req_funct3 inside {F3_SB, F3_SH, F3_SW});
    end
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    rd_d       = opLoad ? bus.req_rd : 5'd0;
  end

  assign timeoutHit = (TIMEOUT_CYC != 0) && (cnt_q == 32'(TIMEOUT_CYC - 1));
  assign reqReady   = (state_q == IDLE);

  // The single aligner serves the incoming request in IDLE and the held access afterwards.
  assign alignF3 = reqReady ? bus.req_funct3 : funct3_q;
  assign alignLo = reqReady ? bus.req_addr[1:0] : addrLo_q;

  lsu_align u_align (
    .funct3_i (alignF3),
    .addrLo_i (alignLo),
    .wdata_i  (bus.req_wdata),
    .rdata_i  (bus.mem_rdata),
    .wstrb_o  (alignStrb),
    .wdata_o  (alignWdata),
    .rdata_o  (alignRdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memWstrb_q  <= '0;
      funct3_q    <= '0;
      addrLo_q    <= '0;
      isStore_q   <= 1'b0;
      rd_q        <= '0;
      cnt_q       <= '0;
      respValid_q <= 1'b0;
      respRd_q    <= '0;
      respRdata_q <= '0;
      respErr_q   <= 1'b0;
      respCode_q  <= RESP_OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            funct3_q  <= bus.req_funct3;
            addrLo_q  <= bus.req_addr[1:0];
            isStore_q <= opStore;
            rd_q      <= rd_d;
            if (illegal || misaligned) begin
              state_q     <= RESP;
              respValid_q <= 1'b1;
              respRd_q    <= rd_d;
              respRdata_q <= '0;
              respErr_q   <= 1'b1;
              respCode_q  <= illegal ? RESP_ILLEGAL : RESP_MISALIGN;
            end else begin
              state_q    <= ACCESS;
              memReq_q   <= 1'b1;
              memWe_q    <= opStore;
              memAddr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              memWdata_q <= opStore ? alignWdata : 32'h0;
              memWstrb_q <= opStore ? alignStrb : 4'b0000;
              cnt_q      <= '0;
            end
          end
        end
        ACCESS: begin
          // An ack arriving in the final timeout cycle still completes normally.
          if (bus.mem_ack || timeoutHit) begin
            state_q     <= RESP;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memWstrb_q  <= 4'b0000;
            respValid_q <= 1'b1;
            respRd_q    <= rd_q;
            respRdata_q <= (bus.mem_ack && !isStore_q) ? alignRdata : 32'h0;
            respErr_q   <= !bus.mem_ack;
            respCode_q  <= bus.mem_ack ? RESP_OK : RESP_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          respValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.busy       = !reqReady || bus.req_valid;
  assign bus.mem_req    = memReq_q;
  assign bus.mem_we     = memWe_q;
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_wdata  = memWdata_q;
  assign bus.mem_wstrb  = memWstrb_q;
  assign bus.resp_valid = respValid_q;
  assign bus.resp_rd    = respRd_q;
  assign bus.resp_rdata = respRdata_q;
  assign bus.resp_err   = respErr_q;
  assign bus.resp_code  = respCode_q;

endmodule
